axi_slave_mem: RTL and testbench

//  Parametrised AXI3 slave memory model/endpoint: full AW/W/B and AR/R channels, FIXED/INCR/WRAP bursts,

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_slave_mem_if.sv | 56 +++++
 rtl/axi_burst_addr_gen.sv | 34 +++
 rtl/axi_slave_mem.sv | 185 ++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 encodings for the slave memory endpoint and its address generator.
package axi_pkg;

  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3} burst_type_t;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;

  // Whole-burst request errors that can be judged from the address-phase fields alone.
  function automatic logic hdr_err(input burst_type_t burst, input logic [2:0] size,
                                   input logic [2:0] max_size, input logic wrap_ok);
    return (burst == RSVD) || (size > max_size) || ((burst == WRAP) && !wrap_ok);
  endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI3 bus bundle between a master and the slave memory endpoint.
interface axi_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [2:0]          awsize;
  axi_pkg::burst_type_t awburst;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  axi_pkg::resp_t      bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]    arlen;
  logic [2:0]          arsize;
  axi_pkg::burst_type_t arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  axi_pkg::resp_t      rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts plus WRAP legality.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  burst_type_t       burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              wrap_ok
);
  logic [ADDR_W-1:0] bytes, container, lower, incr;
  logic              len_ok;

  assign bytes     = ADDR_W'(1) << size;
  assign container = bytes * (ADDR_W'(len) + ADDR_W'(1));
  assign lower     = addr & ~(container - ADDR_W'(1));
  assign incr      = addr + bytes;
  assign len_ok    = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                     (len == LEN_W'(7)) || (len == LEN_W'(15));
  assign wrap_ok   = len_ok && ((addr & (bytes - ADDR_W'(1))) == '0);

  always_comb begin
    next_addr = incr;
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    if (incr == lower + container) next_addr = lower;
      default: next_addr = incr;
    endcase
  end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave memory: one outstanding write and one outstanding read, byte strobes, SLVERR/DECERR.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic           aclk,
  input  logic           arst,
  axi_slave_mem_if.slave bus,
  output logic [1:0]     wr_state,
  output logic [0:0]     rd_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready; a raised valid
  // and its payload hold until that edge, and ready never waits on anything but state.
  localparam int STRB_W  = DATA_W / 8;
  localparam int STRB_LG = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write path ----------------
  logic [ID_W-1:0]   wr_id;
  logic [ADDR_W-1:0] wr_addr, wg_addr, wg_next, wr_word;
  logic [LEN_W-1:0]  wr_len, wr_beat, wg_len;
  logic [2:0]        wr_size, wg_size;
  burst_type_t       wr_burst, wg_burst;
  logic              wr_slv, wr_dec, wg_wrap_ok, wr_oor, w_hs, beat_last, beat_slv, mem_we;

  assign wg_addr  = (wr_state == W_IDLE) ? bus.awaddr  : wr_addr;
  assign wg_size  = (wr_state == W_IDLE) ? bus.awsize  : wr_size;
  assign wg_len   = (wr_state == W_IDLE) ? bus.awlen   : wr_len;
  assign wg_burst = (wr_state == W_IDLE) ? bus.awburst : wr_burst;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
    .addr(wg_addr), .size(wg_size), .len(wg_len), .burst(wg_burst),
    .next_addr(wg_next), .wrap_ok(wg_wrap_ok)
  );

  assign wr_word   = wr_addr >> STRB_LG;
  assign wr_oor    = wr_word >= ADDR_W'(DEPTH);
  assign w_hs      = bus.wvalid && bus.wready;
  assign beat_last = (wr_beat == wr_len);
  // Once a burst goes SLVERR every remaining beat is dropped, not just the offending one.
  assign beat_slv  = wr_slv || (bus.wid != wr_id) || (bus.wlast != beat_last);
  assign mem_we    = w_hs && !beat_slv && !wr_oor;

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) mem[wr_word[IDX_W-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_state <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bid     <= '0;
      bus.bresp   <= OKAY;
      wr_id <= '0; wr_addr <= '0; wr_len <= '0; wr_beat <= '0; wr_size <= '0;
      wr_burst <= FIXED; wr_slv <= 1'b0; wr_dec <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          bus.awready <= 1'b1;
          if (bus.awvalid && bus.awready) begin
            wr_id <= bus.awid; wr_addr <= bus.awaddr; wr_len <= bus.awlen;
            wr_size <= bus.awsize; wr_burst <= bus.awburst; wr_beat <= '0;
            wr_slv <= hdr_err(bus.awburst, bus.awsize, 3'(STRB_LG), wg_wrap_ok);
            wr_dec <= 1'b0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            wr_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wr_addr <= wg_next;
            wr_beat <= wr_beat + LEN_W'(1);
            wr_slv  <= beat_slv;
            if (wr_oor) wr_dec <= 1'b1;
            if (beat_last) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bid    <= wr_id;
              bus.bresp  <= (wr_dec || wr_oor) ? DECERR : (beat_slv ? SLVERR : OKAY);
              wr_state   <= W_RESP;
            end
          end
        end
        default: begin
          if (bus.bready) begin
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            wr_state    <= W_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- read path ----------------
  logic [ADDR_W-1:0] rd_addr, rg_addr, rg_next, rf_addr, rf_word;
  logic [LEN_W-1:0]  rd_len, rd_beat, rg_len;
  logic [2:0]        rd_size, rg_size;
  burst_type_t       rd_burst, rg_burst;
  logic              rd_slv, rg_wrap_ok, rf_oor, rf_slv;
  logic [DATA_W-1:0] rf_data;
  resp_t             rf_resp;

  assign rg_addr  = (rd_state == R_IDLE) ? bus.araddr  : rd_addr;
  assign rg_size  = (rd_state == R_IDLE) ? bus.arsize  : rd_size;
  assign rg_len   = (rd_state == R_IDLE) ? bus.arlen   : rd_len;
  assign rg_burst = (rd_state == R_IDLE) ? bus.arburst : rd_burst;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
    .addr(rg_addr), .size(rg_size), .len(rg_len), .burst(rg_burst),
    .next_addr(rg_next), .wrap_ok(rg_wrap_ok)
  );

  // The beat to present next: the start address on AR, else the following address.
  assign rf_addr = (rd_state == R_IDLE) ? bus.araddr : rg_next;
  assign rf_word = rf_addr >> STRB_LG;
  assign rf_oor  = rf_word >= ADDR_W'(DEPTH);
  assign rf_slv  = (rd_state == R_IDLE) ?
                   hdr_err(bus.arburst, bus.arsize, 3'(STRB_LG), rg_wrap_ok) : rd_slv;
  assign rf_data = (rf_oor || rf_slv) ? '0 : mem[rf_word[IDX_W-1:0]];
  assign rf_resp = rf_oor ? DECERR : (rf_slv ? SLVERR : OKAY);

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rd_state <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rlast   <= 1'b0;
      bus.rid     <= '0;
      bus.rdata   <= '0;
      bus.rresp   <= OKAY;
      rd_addr <= '0; rd_len <= '0; rd_beat <= '0; rd_size <= '0;
      rd_burst <= FIXED; rd_slv <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          bus.arready <= 1'b1;
          if (bus.arvalid && bus.arready) begin
            rd_addr <= bus.araddr; rd_len <= bus.arlen; rd_size <= bus.arsize;
            rd_burst <= bus.arburst; rd_beat <= '0; rd_slv <= rf_slv;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b1;
            bus.rid     <= bus.arid;
            bus.rdata   <= rf_data;
            bus.rresp   <= rf_resp;
            bus.rlast   <= (bus.arlen == '0);
            rd_state    <= R_DATA;
          end
        end
        default: begin
          if (bus.rvalid && bus.rready) begin
            if (bus.rlast) begin
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.arready <= 1'b1;
              rd_state    <= R_IDLE;
            end else begin
              rd_addr   <= rg_next;
              rd_beat   <= rd_beat + LEN_W'(1);
              bus.rdata <= rf_data;
              bus.rresp <= rf_resp;
              bus.rlast <= ((rd_beat + LEN_W'(1)) == rd_len);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, strobes, error responses, back-pressure, reset abort.
module tb_axi_slave_mem;
  import axi_pkg::*;

  logic       aclk = 1'b0;
  logic       arst = 1'b0;
  logic [1:0] wr_state;
  logic [0:0] rd_state;
  int         compared = 0;
  int         mismatched = 0;
  logic [31:0] wbuf [16];
  logic [31:0] exp_q [$];
  logic [1:0]  resp;
  logic [3:0]  id;
  logic [31:0] d;
  logic        l;

  axi_slave_mem_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(4)) bus ();

  axi_slave_mem #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .LEN_W(4), .DEPTH(1024)) dut (
    .aclk(aclk), .arst(arst), .bus(bus), .wr_state(wr_state), .rd_state(rd_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic do_aw(input logic [3:0] i, input logic [31:0] a, input logic [3:0] ln,
                       input logic [2:0] sz, input burst_type_t bt);
    int n = 0;
    bus.awid = i; bus.awaddr = a; bus.awlen = ln; bus.awsize = sz; bus.awburst = bt;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 50) begin tick(); n++; end
    if (n >= 50) tmo("aw_wait");
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [3:0] i, input logic [31:0] dat, input logic [3:0] st,
                      input logic last);
    int n = 0;
    bus.wid = i; bus.wdata = dat; bus.wstrb = st; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 50) begin tick(); n++; end
    if (n >= 50) tmo("w_wait");
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic do_b(input int delay, output logic [1:0] r, output logic [3:0] bi);
    int n = 0;
    while (!bus.bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) tmo("b_wait");
    for (int k = 0; k < delay; k++) begin
      check("b_hold_awready", 32'(bus.awready), 32'd0);
      check("b_hold_bvalid", 32'(bus.bvalid), 32'd1);
      tick();
    end
    bus.bready = 1'b1;
    r = bus.bresp; bi = bus.bid;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] i, input logic [31:0] a, input logic [3:0] ln,
                       input logic [2:0] sz, input burst_type_t bt);
    int n = 0;
    bus.arid = i; bus.araddr = a; bus.arlen = ln; bus.arsize = sz; bus.arburst = bt;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (n >= 50) tmo("ar_wait");
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic do_r(output logic [31:0] dat, output logic [1:0] r, output logic last,
                      output logic [3:0] ri);
    int n = 0;
    while (!bus.rvalid && n < 50) begin tick(); n++; end
    if (n >= 50) tmo("r_wait");
    dat = bus.rdata; r = bus.rresp; last = bus.rlast; ri = bus.rid;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] i, input logic [3:0] wi, input logic [31:0] a,
                             input logic [3:0] ln, input burst_type_t bt, input logic [3:0] st,
                             output logic [1:0] r);
    logic [3:0] bi;
    do_aw(i, a, ln, 3'd2, bt);
    for (int k = 0; k <= int'(ln); k++) do_w(wi, wbuf[k], st, k == int'(ln));
    do_b(0, r, bi);
    check("bid", 32'(bi), 32'(i));
  endtask

  // Pops one expected word per beat from exp_q; rlast expected only on the final beat.
  task automatic read_check(input string tag, input logic [3:0] i, input logic [31:0] a,
                            input logic [3:0] ln, input logic [2:0] sz, input burst_type_t bt,
                            input logic [1:0] er);
    logic [31:0] dat;
    logic [1:0]  r;
    logic        last;
    logic [3:0]  ri;
    do_ar(i, a, ln, sz, bt);
    for (int k = 0; k <= int'(ln); k++) begin
      do_r(dat, r, last, ri);
      check({tag, "_rdata"}, dat, exp_q.pop_front());
      check({tag, "_rresp"}, 32'(r), 32'(er));
      check({tag, "_rlast"}, 32'(last), 32'(k == int'(ln)));
      check({tag, "_rid"}, 32'(ri), 32'(i));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = INCR;
    bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = INCR;
    bus.rready = 0;

    // Reset state
    #2 arst = 1'b1;
    #1;
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rlast", 32'(bus.rlast), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_bresp", 32'(bus.bresp), 32'(OKAY));
    check("rst_ids", {24'd0, bus.bid, bus.rid}, 32'd0);
    tick(); tick();
    arst = 1'b0;
    tick();

    // INCR len=3 @0x10 write and read back
    for (int k = 0; k < 4; k++) wbuf[k] = 32'h1111_1111 * (k + 1);
    write_burst(4'd1, 4'd1, 32'h10, 4'd3, INCR, 4'hF, resp);
    check("incr_bresp", 32'(resp), 32'(OKAY));
    do_ar(4'd5, 32'h10, 4'd3, 3'd2, INCR);
    check("r_latency_rvalid", 32'(bus.rvalid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      do_r(d, resp, l, id);
      check("incr_rdata", d, 32'h1111_1111 * (k + 1));
      check("incr_rlast", 32'(l), 32'(k == 3));
      check("incr_rresp", 32'(resp), 32'(OKAY));
      check("incr_rid", 32'(id), 32'd5);
    end

    // rready held low 5 cycles on beat 2
    do_ar(4'd6, 32'h10, 4'd3, 3'd2, INCR);
    do_r(d, resp, l, id);
    check("stall_beat1", d, 32'h1111_1111);
    for (int k = 0; k < 5; k++) begin
      check("stall_rvalid", 32'(bus.rvalid), 32'd1);
      check("stall_rdata", bus.rdata, 32'h2222_2222);
      check("stall_rlast", 32'(bus.rlast), 32'd0);
      tick();
    end
    for (int k = 1; k < 4; k++) begin
      do_r(d, resp, l, id);
      check("stall_rdata_after", d, 32'h1111_1111 * (k + 1));
      check("stall_rlast_after", 32'(l), 32'(k == 3));
    end

    // bready delayed 3 cycles: awready stays low until the B handshake
    do_aw(4'd2, 32'h24, 4'd0, 3'd2, INCR);
    do_w(4'd2, 32'h5A5A_5A5A, 4'hF, 1'b1);
    do_b(3, resp, id);
    check("bdelay_bresp", 32'(resp), 32'(OKAY));
    check("bdelay_bid", 32'(id), 32'd2);
    check("bdelay_awready_after", 32'(bus.awready), 32'd1);

    // WRAP len=3 @0x18
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    write_burst(4'd3, 4'd3, 32'h18, 4'd3, WRAP, 4'hF, resp);
    check("wrap_bresp", 32'(resp), 32'(OKAY));
    exp_q.push_back(32'hC); exp_q.push_back(32'hD); exp_q.push_back(32'hA); exp_q.push_back(32'hB);
    read_check("wrap_incr_rd", 4'd7, 32'h10, 4'd3, 3'd2, INCR, OKAY);
    exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC); exp_q.push_back(32'hD);
    read_check("wrap_rd", 4'd8, 32'h18, 4'd3, 3'd2, WRAP, OKAY);

    // Byte strobes on a preset word
    wbuf[0] = 32'hFFFF_FFFF;
    write_burst(4'd4, 4'd4, 32'h20, 4'd0, INCR, 4'hF, resp);
    wbuf[0] = 32'h0;
    write_burst(4'd4, 4'd4, 32'h20, 4'd0, INCR, 4'b1010, resp);
    check("strb_bresp", 32'(resp), 32'(OKAY));
    exp_q.push_back(32'h00FF_00FF);
    read_check("strb_rd", 4'd9, 32'h20, 4'd0, 3'd2, INCR, OKAY);

    // DECERR just past the end; word 0 (same low index bits) must survive
    wbuf[0] = 32'h1234_5678;
    write_burst(4'd1, 4'd1, 32'h0, 4'd0, INCR, 4'hF, resp);
    wbuf[0] = 32'hDEAD_BEEF;
    write_burst(4'd1, 4'd1, 32'h1000, 4'd0, INCR, 4'hF, resp);
    check("dec_bresp", 32'(resp), 32'(DECERR));
    exp_q.push_back(32'h1234_5678);
    read_check("dec_mem_kept", 4'd2, 32'h0, 4'd0, 3'd2, INCR, OKAY);
    exp_q.push_back(32'h0);
    read_check("dec_rd", 4'd3, 32'h1000, 4'd0, 3'd2, INCR, DECERR);

    // SLVERR cases leave memory untouched
    wbuf[0] = 32'h7777_7777;
    write_burst(4'd5, 4'd5, 32'h28, 4'd0, INCR, 4'hF, resp);
    wbuf[0] = 32'h8888_8888;
    write_burst(4'd5, 4'd5, 32'h28, 4'd0, RSVD, 4'hF, resp);
    check("slv_rsvd_bresp", 32'(resp), 32'(SLVERR));
    write_burst(4'd5, 4'd6, 32'h28, 4'd0, INCR, 4'hF, resp);
    check("slv_wid_bresp", 32'(resp), 32'(SLVERR));
    exp_q.push_back(32'h7777_7777);
    read_check("slv_mem_kept", 4'd4, 32'h28, 4'd0, 3'd2, INCR, OKAY);
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
    read_check("slv_wrap_len2", 4'd5, 32'h28, 4'd2, 3'd2, WRAP, SLVERR);
    exp_q.push_back(32'h0);
    read_check("slv_size", 4'd6, 32'h28, 4'd0, 3'd3, INCR, SLVERR);

    // arst pulsed while beat 2 of a write is on the bus
    do_aw(4'd9, 32'h40, 4'd3, 3'd2, INCR);
    do_w(4'd9, 32'hE0, 4'hF, 1'b0);
    do_w(4'd9, 32'hE1, 4'hF, 1'b0);
    bus.wid = 4'd9; bus.wdata = 32'hE2; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    arst = 1'b1;
    #1;
    check("abort_wready", 32'(bus.wready), 32'd0);
    check("abort_awready", 32'(bus.awready), 32'd0);
    check("abort_bvalid", 32'(bus.bvalid), 32'd0);
    check("abort_arready", 32'(bus.arready), 32'd0);
    bus.wvalid = 1'b0;
    tick();
    arst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_bvalid", 32'(bus.bvalid), 32'd0);
    end
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE_0000 + 32'(k);
    write_burst(4'd10, 4'd10, 32'h40, 4'd3, INCR, 4'hF, resp);
    check("post_rst_bresp", 32'(resp), 32'(OKAY));
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hC0DE_0000 + 32'(k));
    read_check("post_rst_rd", 4'd11, 32'h40, 4'd3, 3'd2, INCR, OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
